alu_sign_extend: RTL and testbench

ALU_SIGN_EXTEND -- requirements
Module: alu_sign_extend

---
 rtl/alu_sign_extend_pkg.sv | 40 ++++
 rtl/alu_sign_extend_imm_extend.sv | 36 +++
 rtl/alu_sign_extend.sv | 78 +++++++
 tb/tb_alu_sign_extend.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sign_extend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sign_extend_pkg
//  Description : Shared control and parameter definitions for the ALU /
//                immediate-extend slice: datapath widths, ALU operation
//                codes and immediate format codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_sign_extend_pkg;

    // Datapath and instruction-field widths
    localparam int c_xlen        = 32;
    localparam int c_instr_width = 25;

    // ALU operation select codes
    typedef enum logic [3:0] {
        c_alu_add  = 4'b0000,
        c_alu_sub  = 4'b0001,
        c_alu_and  = 4'b0010,
        c_alu_or   = 4'b0011,
        c_alu_xor  = 4'b0100,
        c_alu_sll  = 4'b0101,
        c_alu_srl  = 4'b0110,
        c_alu_sra  = 4'b0111,
        c_alu_slt  = 4'b1000,
        c_alu_sltu = 4'b1001,
        c_alu_nop  = 4'b1111
    } alu_op_e;

    // Immediate format select codes
    typedef enum logic [2:0] {
        c_imm_i = 3'b000,
        c_imm_s = 3'b001,
        c_imm_b = 3'b010,
        c_imm_u = 3'b011,
        c_imm_j = 3'b100
    } imm_src_e;

endpackage : alu_sign_extend_pkg
`default_nettype wire

// File: rtl/alu_sign_extend_imm_extend.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend
//  Description : Combinational immediate decoder. Reassembles and sign-
//                extends the immediate field of instruction bits [31:7]
//                according to the selected instruction format.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_extend
    import alu_sign_extend_pkg::*;
(
    input  logic [c_instr_width-1:0] i_instr_imm,
    input  logic [2:0]               i_imm_src,
    output logic [c_xlen-1:0]        o_imm
);

    // Field reassembly per format; s[24] is instruction bit 31 (the sign bit)
    always_comb begin
        o_imm = '0;
        case (i_imm_src)
            c_imm_i: o_imm = {{20{i_instr_imm[24]}}, i_instr_imm[24:13]};
            c_imm_s: o_imm = {{20{i_instr_imm[24]}}, i_instr_imm[24:18],
                              i_instr_imm[4:0]};
            c_imm_b: o_imm = {{19{i_instr_imm[24]}}, i_instr_imm[24],
                              i_instr_imm[0], i_instr_imm[23:18],
                              i_instr_imm[4:1], 1'b0};
            c_imm_u: o_imm = {i_instr_imm[24:5], 12'b0};
            c_imm_j: o_imm = {{11{i_instr_imm[24]}}, i_instr_imm[24],
                              i_instr_imm[12:5], i_instr_imm[13],
                              i_instr_imm[23:14], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule : imm_extend
`default_nettype wire

// File: rtl/alu_sign_extend.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sign_extend
//  Description : Single-cycle ALU with registered result and zero flag.
//                Operand B is either the register operand or the
//                combinationally extended immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sign_extend
    import alu_sign_extend_pkg::*;
#(
    parameter int XLEN = c_xlen
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               alu_ctrl,
    input  logic                     alu_src,
    input  logic [XLEN-1:0]          src1,
    input  logic [XLEN-1:0]          src2,
    input  logic [c_instr_width-1:0] instr_imm,
    input  logic [2:0]               imm_src,
    output logic [XLEN-1:0]          imm_signed,
    output logic [XLEN-1:0]          results,
    output logic                     zero
);

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] r_results;
    logic            r_zero;

    imm_extend u_imm_extend (
        .i_instr_imm (instr_imm),
        .i_imm_src   (imm_src),
        .o_imm       (w_imm)
    );

    assign imm_signed = w_imm;
    assign w_op_b     = alu_src ? w_imm : src2;
    assign w_shamt    = w_op_b[4:0];

    // ALU operation decode; carries and overflow are discarded by design
    always_comb begin
        w_alu_result = '0;
        case (alu_ctrl)
            c_alu_add:  w_alu_result = src1 + w_op_b;
            c_alu_sub:  w_alu_result = src1 - w_op_b;
            c_alu_and:  w_alu_result = src1 & w_op_b;
            c_alu_or:   w_alu_result = src1 | w_op_b;
            c_alu_xor:  w_alu_result = src1 ^ w_op_b;
            c_alu_sll:  w_alu_result = src1 << w_shamt;
            c_alu_srl:  w_alu_result = src1 >> w_shamt;
            c_alu_sra:  w_alu_result = $signed(src1) >>> w_shamt;
            c_alu_slt:  w_alu_result = {{(XLEN-1){1'b0}},
                                        ($signed(src1) < $signed(w_op_b))};
            c_alu_sltu: w_alu_result = {{(XLEN-1){1'b0}}, (src1 < w_op_b)};
            default:    w_alu_result = '0;
        endcase
    end

    // Result and zero flag register; reset forces the "result is zero" state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_results <= '0;
            r_zero    <= 1'b1;
        end else begin
            r_results <= w_alu_result;
            r_zero    <= (w_alu_result == '0);
        end
    end

    assign results = r_results;
    assign zero    = r_zero;

endmodule : alu_sign_extend
`default_nettype wire

// File: tb/tb_alu_sign_extend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sign_extend
//  Description : Directed self-checking bench for alu_sign_extend.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sign_extend;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [24:0] instr_imm;
    logic [2:0]  imm_src;
    logic [31:0] imm_signed;
    logic [31:0] results;
    logic        zero;

    int checks;
    int errors;

    alu_sign_extend #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_ctrl   (alu_ctrl),
        .alu_src    (alu_src),
        .src1       (src1),
        .src2       (src2),
        .instr_imm  (instr_imm),
        .imm_src    (imm_src),
        .imm_signed (imm_signed),
        .results    (results),
        .zero       (zero)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one operation, then sample 1 ns after the capturing edge
    task automatic run_op(input logic [3:0] ctrl, input logic asrc,
                          input logic [31:0] a, input logic [31:0] b);
        alu_ctrl = ctrl;
        alu_src  = asrc;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        alu_ctrl  = 4'b0000;
        alu_src   = 1'b0;
        src1      = '0;
        src2      = '0;
        instr_imm = '0;
        imm_src   = 3'b000;

        // Reset held across edges
        repeat (2) @(posedge clk);
        #1;
        chk32("reset_results", results, 32'h0000_0000);
        chk1 ("reset_zero",    zero,    1'b1);

        // Release reset with NOP selected
        alu_ctrl = 4'b1111;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        chk32("post_reset_nop_results", results, 32'h0000_0000);
        chk1 ("post_reset_nop_zero",    zero,    1'b1);

        // I-type immediate + ADD
        instr_imm = 25'h1F80000;
        imm_src   = 3'b000;
        #1;
        chk32("imm_i", imm_signed, 32'hFFFF_FFC0);
        run_op(4'b0000, 1'b1, 32'h0000_2000, 32'h0);
        chk32("add_imm_i", results, 32'h0000_1FC0);
        chk1 ("add_imm_i_zero", zero, 1'b0);

        // S-type: 25'h0070005 has bit 18 set, which lands in imm[5]
        instr_imm = 25'h0070005;
        imm_src   = 3'b001;
        #1;
        chk32("imm_s_bit18", imm_signed, 32'h0000_0025);
        instr_imm = 25'h0000005;
        #1;
        chk32("imm_s", imm_signed, 32'h0000_0005);
        run_op(4'b0000, 1'b1, 32'h0000_3000, 32'h0);
        chk32("add_imm_s", results, 32'h0000_3005);

        // B-type: sign bit plus s[0] -> imm[11]
        instr_imm = 25'h1000001;
        imm_src   = 3'b010;
        #1;
        chk32("imm_b", imm_signed, 32'hFFFF_F800);

        // U-type
        instr_imm = 25'h0ABCDE5;
        imm_src   = 3'b011;
        #1;
        chk32("imm_u", imm_signed, 32'h55E6_F000);

        // J-type: s[12:5] -> imm[19:12], s[13] -> imm[11]
        instr_imm = 25'h0003FE0;
        imm_src   = 3'b100;
        #1;
        chk32("imm_j", imm_signed, 32'h000F_F800);

        // Reserved format
        imm_src = 3'b101;
        #1;
        chk32("imm_reserved", imm_signed, 32'h0000_0000);

        // Register operand ADD
        run_op(4'b0000, 1'b0, 32'h0000_5000, 32'h0000_0FFF);
        chk32("add_reg", results, 32'h0000_5FFF);
        chk1 ("add_reg_zero", zero, 1'b0);

        // SUB to zero
        run_op(4'b0001, 1'b0, 32'h0000_1234, 32'h0000_1234);
        chk32("sub_zero", results, 32'h0000_0000);
        chk1 ("sub_zero_flag", zero, 1'b1);

        // SUB wrap
        run_op(4'b0001, 1'b0, 32'h0000_0000, 32'h0000_0001);
        chk32("sub_wrap", results, 32'hFFFF_FFFF);

        // ADD overflow wraps to zero
        run_op(4'b0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk32("add_wrap", results, 32'h0000_0000);
        chk1 ("add_wrap_zero", zero, 1'b1);

        // Logic ops
        run_op(4'b0010, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk32("and", results, 32'hF000_F000);
        run_op(4'b0011, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk32("or", results, 32'hFFF0_FFF0);
        run_op(4'b0100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk32("xor", results, 32'h0FF0_0FF0);

        // Compare and shift with A = 0x80000000, B = 1
        run_op(4'b1000, 1'b0, 32'h8000_0000, 32'h0000_0001);
        chk32("slt", results, 32'h0000_0001);
        run_op(4'b1001, 1'b0, 32'h8000_0000, 32'h0000_0001);
        chk32("sltu", results, 32'h0000_0000);
        chk1 ("sltu_zero", zero, 1'b1);
        run_op(4'b0111, 1'b0, 32'h8000_0000, 32'h0000_0001);
        chk32("sra", results, 32'hC000_0000);

        // Shift boundaries; only B[4:0] is used as the amount
        run_op(4'b0111, 1'b0, 32'h8765_4321, 32'h0000_0020);
        chk32("sra_by0", results, 32'h8765_4321);
        run_op(4'b0101, 1'b0, 32'hFFFF_FFFF, 32'h0000_001F);
        chk32("sll_by31", results, 32'h8000_0000);
        run_op(4'b0110, 1'b0, 32'hFFFF_FFFF, 32'h0000_001F);
        chk32("srl_by31", results, 32'h0000_0001);

        // Undefined code and NOP
        run_op(4'b1010, 1'b0, 32'h1234_5678, 32'h1111_1111);
        chk32("undef_code", results, 32'h0000_0000);
        chk1 ("undef_zero", zero, 1'b1);
        run_op(4'b1111, 1'b0, 32'h1234_5678, 32'h1111_1111);
        chk32("nop", results, 32'h0000_0000);

        // Asynchronous reset mid-stream, between clock edges
        run_op(4'b0000, 1'b0, 32'h0000_0010, 32'h0000_0020);
        chk32("pre_async_rst", results, 32'h0000_0030);
        #2;
        rst = 1'b1;
        #1;
        chk32("async_rst_results", results, 32'h0000_0000);
        chk1 ("async_rst_zero",    zero,    1'b1);
        @(posedge clk);
        #1;
        chk32("rst_hold_results", results, 32'h0000_0000);
        rst = 1'b0;

        // First edge after release registers current inputs
        run_op(4'b0011, 1'b0, 32'h0000_00F0, 32'h0000_000F);
        chk32("after_rst_or", results, 32'h0000_00FF);
        chk1 ("after_rst_zero", zero, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_sign_extend
`default_nettype wire
